// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32I-style datapath sharing one memory port.
// Strobes are decoded combinationally from state/opcode; status flags and the retire counter are registered.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [6:0]  opcode,
    input  logic        br_taken,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_a_sel,
    output logic        alu_b_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic        bus_err,
    output logic [31:0] instret
);

    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [31:0]       instret_q, instret_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic       op_legal, op_load, op_store, op_branch, op_jal, op_jalr;
    logic [1:0] op_a_sel;
    logic       op_b_sel;

    // Opcode class and ALU operand selects for the latched instruction
    always_comb begin
        op_legal  = 1'b1;
        op_load   = 1'b0;
        op_store  = 1'b0;
        op_branch = 1'b0;
        op_jal    = 1'b0;
        op_jalr   = 1'b0;
        op_a_sel  = 2'd0;
        op_b_sel  = 1'b0;
        case (opcode)
            OPC_OP:     ;
            OPC_OP_IMM: op_b_sel = 1'b1;
            OPC_LOAD:   begin op_load  = 1'b1; op_b_sel = 1'b1; end
            OPC_STORE:  begin op_store = 1'b1; op_b_sel = 1'b1; end
            OPC_JALR:   begin op_jalr  = 1'b1; op_b_sel = 1'b1; end
            OPC_LUI:    begin op_a_sel = 2'd2; op_b_sel = 1'b1; end
            OPC_AUIPC:  begin op_a_sel = 2'd1; op_b_sel = 1'b1; end
            OPC_BRANCH: op_branch = 1'b1;
            OPC_JAL:    op_jal    = 1'b1;
            default:    op_legal  = 1'b0;
        endcase
    end

    // Next state, wait counter, status and strobes; the counter stays zero outside memory states
    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        instret_d    = instret_q;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_a_sel    = 2'd0;
        alu_b_sel    = 1'b0;
        reg_we       = 1'b0;
        wb_sel       = 2'd0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                if (mem_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_DECODE: begin
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d   = S_TRAP;
                    illegal_d = 1'b1;
                end
            end

            S_EXEC: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                if (op_branch) begin
                    pc_we     = 1'b1;
                    pc_src    = {1'b0, br_taken};
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end else if (op_load || op_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end

            S_MEM: begin
                alu_a_sel    = op_a_sel;
                alu_b_sel    = op_b_sel;
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = op_store;
                if (mem_ack) begin
                    if (op_store) begin
                        pc_we     = 1'b1;
                        instret_d = instret_q + 32'd1;
                        state_d   = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (wait_q == WAIT_LIMIT) begin
                    state_d   = S_TRAP;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            S_WB: begin
                alu_a_sel = op_a_sel;
                alu_b_sel = op_b_sel;
                reg_we    = 1'b1;
                pc_we     = 1'b1;
                instret_d = instret_q + 32'd1;
                state_d   = S_FETCH;
                if (op_load) begin
                    wb_sel = 2'd1;
                end else if (op_jal || op_jalr) begin
                    wb_sel = 2'd2;
                end
                if (op_jal) begin
                    pc_src = 2'd1;
                end else if (op_jalr) begin
                    pc_src = 2'd2;
                end
            end

            S_TRAP: state_d = S_TRAP;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: each instruction is expanded into its expected cycle-by-cycle phases from the opcode tables.
module tb_multicycle_ctrl;

    localparam int unsigned TO = 4;

    localparam logic [6:0] I_OP_IMM = 7'b0010011;
    localparam logic [6:0] I_OP     = 7'b0110011;
    localparam logic [6:0] I_BRANCH = 7'b1100011;
    localparam logic [6:0] I_LUI    = 7'b0110111;
    localparam logic [6:0] I_AUIPC  = 7'b0010111;
    localparam logic [6:0] I_JAL    = 7'b1101111;
    localparam logic [6:0] I_JALR   = 7'b1100111;
    localparam logic [6:0] I_LOAD   = 7'b0000011;
    localparam logic [6:0] I_STORE  = 7'b0100011;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        br_taken = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, reg_we;
    logic [1:0]  pc_src, alu_a_sel, wb_sel;
    logic        illegal, bus_err;
    logic [31:0] instret;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_instret = '0;

    logic [6:0]  legal_ops [9] = '{I_OP_IMM, I_OP, I_BRANCH, I_LUI, I_AUIPC,
                                   I_JAL, I_JALR, I_LOAD, I_STORE};

    multicycle_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn), .opcode(opcode), .br_taken(br_taken), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
        .reg_we(reg_we), .wb_sel(wb_sel), .illegal(illegal), .bus_err(bus_err),
        .instret(instret)
    );

    always #5 clk = ~clk;

    wire [12:0] obs_vec = {mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
                           alu_a_sel, alu_b_sel, reg_we, wb_sel};

    function automatic logic [12:0] mk(input logic req, input logic we, input logic asel,
                                       input logic irwe, input logic pcwe, input logic [1:0] pcs,
                                       input logic [1:0] a, input logic b, input logic rwe,
                                       input logic [1:0] wbs);
        return {req, we, asel, irwe, pcwe, pcs, a, b, rwe, wbs};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Operand-select table for the execute and following phases
    function automatic logic [2:0] sel_of(input logic [6:0] op);
        case (op)
            I_OP_IMM, I_LOAD, I_STORE, I_JALR: return {2'd0, 1'b1};
            I_LUI:   return {2'd2, 1'b1};
            I_AUIPC: return {2'd1, 1'b1};
            default: return {2'd0, 1'b0};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic ack, input logic br);
        @(negedge clk);
        mem_ack  = ack;
        br_taken = br;
        #1;
    endtask

    task automatic assert_reset();
        @(negedge clk);
        rstn = 1'b0;
        #1;
        exp_instret = '0;
        chk("rst_vec", obs_vec, 0);
        chk("rst_instret", instret, 0);
        chk("rst_flags", {illegal, bus_err}, 0);
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        mem_ack = 1'b0;
        rstn = 1'b1;
        #1;
        chk("idle_vec", obs_vec, 0);
    endtask

    task automatic trap_hold(input int n, input logic [1:0] flags);
        for (int c = 0; c < n; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk("trap_vec", obs_vec, 0);
        end
        chk("trap_flags", {illegal, bus_err}, flags);
    endtask

    // fw/mw: cycles without ack before the ack in fetch/memory; rst_mid pulls reset in the 2nd mem cycle
    task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic br,
                             input bit rst_mid, output int cycles, output bit trapped);
        logic [2:0] s;
        logic [1:0] a, pcs, wbs;
        logic       b, ldst, st;
        cycles  = 0;
        trapped = 1'b0;
        s = sel_of(op);
        a = s[2:1];
        b = s[0];
        ldst = (op == I_LOAD) || (op == I_STORE);
        for (int i = 0; i <= fw; i++) begin
            drive(i == fw, 1'b0);
            cycles++;
            if (i == int'(TO) + 1) begin
                trapped = 1'b1;
                chk("fetch_to_vec", obs_vec, 0);
                chk("fetch_to_buserr", bus_err, 1);
                return;
            end
            if (i == 0) begin
                chk("instret", instret, exp_instret);
                chk("flags_clear", {illegal, bus_err}, 0);
            end
            chk("fetch", obs_vec, mk(1, 0, 0, i == fw, 0, 0, 0, 0, 0, 0));
        end
        opcode = op;
        drive(1'($urandom_range(0, 1)), 1'b0);
        cycles++;
        chk("decode", obs_vec, 0);
        if (!is_legal(op)) begin
            drive(1'b0, 1'b0);
            trapped = 1'b1;
            chk("illegal_vec", obs_vec, 0);
            chk("illegal_flag", illegal, 1);
            return;
        end
        drive(1'($urandom_range(0, 1)), br);
        cycles++;
        if (op == I_BRANCH) begin
            chk("exec_branch", obs_vec, mk(0, 0, 0, 0, 1, {1'b0, br}, a, b, 0, 0));
            exp_instret++;
            return;
        end
        chk("exec", obs_vec, mk(0, 0, 0, 0, 0, 0, a, b, 0, 0));
        if (ldst) begin
            for (int j = 0; j <= mw; j++) begin
                drive(j == mw, 1'b0);
                cycles++;
                if (j == int'(TO) + 1) begin
                    trapped = 1'b1;
                    chk("mem_to_vec", obs_vec, 0);
                    chk("mem_to_buserr", bus_err, 1);
                    return;
                end
                if (rst_mid && j == 1) begin
                    rstn = 1'b0;
                    #1;
                    exp_instret = '0;
                    trapped = 1'b1;
                    chk("rst_mid_req", mem_req, 0);
                    chk("rst_mid_instret", instret, 0);
                    return;
                end
                st = (op == I_STORE) && (j == mw);
                chk("mem", obs_vec, mk(1, op == I_STORE, 1, 0, st, 0, a, b, 0, 0));
                if (st) begin
                    exp_instret++;
                    return;
                end
            end
        end
        drive(1'($urandom_range(0, 1)), 1'b0);
        cycles++;
        wbs = (op == I_LOAD) ? 2'd1 : (op == I_JAL || op == I_JALR) ? 2'd2 : 2'd0;
        pcs = (op == I_JAL) ? 2'd1 : (op == I_JALR) ? 2'd2 : 2'd0;
        chk("wb", obs_vec, mk(0, 0, 0, 0, 1, pcs, a, b, 1, wbs));
        exp_instret++;
    endtask

    initial begin
        int cyc;
        bit tr;

        assert_reset();
        release_reset();

        run_instr(I_OP_IMM, 1, 0, 0, 0, cyc, tr);
        chk("addi_cycles", 32'(cyc), 5);
        run_instr(I_BRANCH, 0, 0, 1, 0, cyc, tr);
        run_instr(I_BRANCH, 2, 0, 0, 0, cyc, tr);
        run_instr(I_LOAD, 0, 3, 0, 0, cyc, tr);
        run_instr(I_STORE, 1, 0, 0, 0, cyc, tr);
        run_instr(I_JALR, 0, 0, 0, 0, cyc, tr);
        run_instr(I_JAL, 0, 0, 0, 0, cyc, tr);
        run_instr(I_LUI, 0, 0, 0, 0, cyc, tr);
        run_instr(I_AUIPC, 0, 0, 0, 0, cyc, tr);
        run_instr(I_OP, 0, 0, 0, 0, cyc, tr);
        run_instr(I_OP_IMM, TO, 0, 0, 0, cyc, tr);
        chk("ack_at_limit_no_trap", 32'(tr), 0);
        run_instr(I_LOAD, 0, TO, 0, 0, cyc, tr);
        chk("mem_ack_at_limit_no_trap", 32'(tr), 0);

        for (int n = 0; n < 40; n++) begin
            run_instr(legal_ops[$urandom_range(0, 8)], int'($urandom_range(0, TO)),
                      int'($urandom_range(0, TO)), 1'($urandom_range(0, 1)), 0, cyc, tr);
            chk("rand_no_trap", 32'(tr), 0);
        end
        run_instr(I_OP, 0, 0, 0, 0, cyc, tr);

        // Reset in the middle of a data access
        run_instr(I_STORE, 0, 3, 0, 1, cyc, tr);
        chk("rst_mid_taken", 32'(tr), 1);
        release_reset();
        run_instr(I_OP, 0, 0, 0, 0, cyc, tr);

        run_instr(7'b0000000, 0, 0, 0, 0, cyc, tr);
        chk("illegal_trapped", 32'(tr), 1);
        trap_hold(20, 2'b10);
        assert_reset();
        release_reset();

        run_instr(I_OP_IMM, TO + 1, 0, 0, 0, cyc, tr);
        chk("fetch_timeout_trapped", 32'(tr), 1);
        chk("fetch_timeout_cycles", 32'(cyc), TO + 2);
        trap_hold(6, 2'b01);
        assert_reset();
        release_reset();

        run_instr(I_LOAD, 0, TO + 1, 0, 0, cyc, tr);
        chk("mem_timeout_trapped", 32'(tr), 1);
        trap_hold(4, 2'b01);
        assert_reset();
        release_reset();
        run_instr(I_OP, 0, 0, 0, 0, cyc, tr);
        run_instr(I_OP, 0, 0, 0, 0, cyc, tr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max mem wait cycles before bus error (1..65535).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port opcode  input  7  instr[6:0] of latched IR.
REQ-005 SHALL have port br_taken  input  1  ALU branch-compare result, valid in EXEC.
REQ-006 SHALL have port mem_ack  input  1  shared memory port completion, one-cycle pulse.
REQ-007 SHALL have port mem_req  output  1  shared memory request, held until ack.
REQ-008 SHALL have port mem_we  output  1  store strobe, qualifies mem_req.
REQ-009 SHALL have port mem_addr_sel  output  1  0 = PC (fetch), 1 = ALU result (data).
REQ-010 SHALL have port ir_we  output  1  IR load enable.
REQ-011 SHALL have port pc_we  output  1  PC update enable.
REQ-012 SHALL have port pc_src  output  2  0 = PC+4, 1 = PC+imm, 2 = ALU result with bit0 cleared.
REQ-013 SHALL have port alu_a_sel  output  2  0 = rs1, 1 = PC, 2 = zero.
REQ-014 SHALL have port alu_b_sel  output  1  0 = rs2, 1 = imm.
REQ-015 SHALL have port reg_we  output  1  register-file write enable.
REQ-016 SHALL have port wb_sel  output  2  0 = ALU, 1 = load data, 2 = PC+4.
REQ-017 SHALL have port illegal  output  1  sticky illegal-opcode flag.
REQ-018 SHALL have port bus_err  output  1  sticky memory-timeout flag.
REQ-019 SHALL have port instret  output  32  retired-instruction counter.

Function
REQ-020 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs combinational from state, opcode, br_taken, mem_ack; unlisted outputs 0.
REQ-021 Legal opcodes SHALL be 0010011 OP-IMM, 0110011 OP, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 0000011 LOAD, 0100011 STORE.
REQ-022 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-023 FETCH: mem_req=1, mem_addr_sel=0, mem_we=0; ir_we=mem_ack in same cycle; on mem_ack -> DECODE, else stay.
REQ-024 DECODE: one cycle, no strobes; illegal opcode -> TRAP with illegal set; else -> EXEC.
REQ-025 EXEC operand selects: OP a=0 b=0; OP-IMM/LOAD/STORE/JALR a=0 b=1; LUI a=2 b=1; AUIPC a=1 b=1; BRANCH a=0 b=0; JAL don't-care (drive 0).
REQ-026 EXEC BRANCH: pc_we=1, pc_src=br_taken?1:0, instret+1, -> FETCH.
REQ-027 EXEC LOAD/STORE -> MEM; all other legal opcodes -> WB.
REQ-028 MEM: operand selects held as EXEC; mem_req=1, mem_addr_sel=1, mem_we=1 for STORE only; on mem_ack LOAD -> WB; STORE asserts pc_we=1, pc_src=0, instret+1, -> FETCH.
REQ-029 WB: operand selects held as EXEC; reg_we=1, pc_we=1, instret+1, -> FETCH; wb_sel=1 LOAD, 2 JAL/JALR, else 0; pc_src=1 JAL, 2 JALR, else 0.
REQ-030 Wait counter SHALL clear on entering FETCH/MEM and on mem_ack, increment each FETCH/MEM cycle without mem_ack; at count==TIMEOUT with no ack -> TRAP, bus_err set; ack in that cycle wins.
REQ-031 mem_ack outside FETCH/MEM SHALL be ignored.
REQ-032 TRAP: all strobes 0, absorbing until reset; illegal/bus_err hold.
REQ-033 instret SHALL wrap 0xFFFFFFFF -> 0 and increment at most once per instruction.

Reset
REQ-034 rstn low SHALL immediately force state IDLE, wait counter 0, instret 0, illegal 0, bus_err 0, all outputs 0, including mid-memory-transaction.
REQ-035 First mem_req SHALL assert in the second rising edge after rstn deassert (IDLE one cycle).

Verification
REQ-036 ADDI (0x00500093), ack one cycle after req -> FETCH,DECODE,EXEC,WB; reg_we=1 wb_sel=0 pc_src=0 in WB; instret=1; 5 cycles incl. FETCH wait.
REQ-037 BEQ br_taken=1 then br_taken=0 -> pc_src=1 then 0 in EXEC, reg_we never 1, instret=2.
REQ-038 LW with 3-cycle data ack, then SW -> mem_we=0/mem_addr_sel=1 for LW, WB wb_sel=1; SW mem_we=1, no WB, instret=2.
REQ-039 JALR opcode 1100111 -> WB wb_sel=2 pc_src=2; opcode 0000000 -> TRAP, illegal=1, mem_req stays 0 for 20 cycles.
REQ-040 TIMEOUT=4, no ack in FETCH -> TRAP after 4 waiting cycles, bus_err=1; ack in cycle 4 instead -> DECODE, bus_err=0.
REQ-041 rstn low during MEM -> mem_req drops asynchronously, instret=0; after release IDLE then FETCH.
